// File: rtl/sram_fifo_ctrl_if.sv
// Stream bundle for sram_fifo_ctrl: producer side (s_*), consumer side (m_*) and the occupancy count.
interface sram_fifo_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W:0]   count;

    modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data, count);
    modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data, count);
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Runs a dual-port SRAM (A write-only, B read-only) as a FIFO, with a 2-entry output buffer
// that hides the one-cycle read latency.
module sram_fifo_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              clr,
    sram_fifo_ctrl_if.slave   st,
    output logic [ADDR_W-1:0] sram_aa,
    output logic [DATA_W-1:0] sram_ia,
    output logic              sram_csba,
    output logic              sram_weba,
    output logic              sram_reba,
    output logic              sram_oeba,
    output logic [ADDR_W-1:0] sram_ab,
    output logic              sram_csbb,
    output logic              sram_webb,
    output logic              sram_rebb,
    output logic              sram_oebb,
    output logic [DATA_W-1:0] sram_ib,
    input  logic [DATA_W-1:0] sram_ob
);
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wptr_r;
    logic [ADDR_W-1:0] rptr_r;
    logic [ADDR_W:0]   mem_cnt_r;
    logic [ADDR_W:0]   mem_cnt_next_s;
    logic [ADDR_W:0]   count_r;
    logic              inflight_r;
    logic [1:0]        ob_cnt_r;
    logic [1:0]        ob_cnt_next_s;
    logic [DATA_W-1:0] ob0_r;
    logic [DATA_W-1:0] ob1_r;
    logic              s_ready_r;
    logic              m_valid_r;
    logic              oebb_r;
    logic              push_s;
    logic              pop_s;
    logic              issue_s;
    logic [2:0]        ob_room_s;

    // Handshake decode, read-issue decision and next occupancy values.
    always_comb begin
        push_s         = st.s_valid & s_ready_r & ~clr;
        pop_s          = m_valid_r & st.m_ready;
        // Buffer slots still claimed after this cycle; a read may only be issued if one stays free.
        ob_room_s      = {1'b0, ob_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s        = ~clr & (mem_cnt_r != {(ADDR_W+1){1'b0}}) & (ob_room_s < 3'd2);
        mem_cnt_next_s = mem_cnt_r + {{ADDR_W{1'b0}}, push_s} - {{ADDR_W{1'b0}}, issue_s};
        case ({inflight_r, pop_s})
            2'b10:   ob_cnt_next_s = ob_cnt_r + 2'd1;
            2'b01:   ob_cnt_next_s = ob_cnt_r - 2'd1;
            default: ob_cnt_next_s = ob_cnt_r;
        endcase
    end

    assign sram_csba = ~push_s;
    assign sram_weba = ~push_s;
    assign sram_aa   = wptr_r;
    assign sram_ia   = st.s_data;
    assign sram_reba = 1'b1;
    assign sram_oeba = 1'b1;
    assign sram_csbb = ~issue_s;
    assign sram_rebb = ~issue_s;
    assign sram_ab   = rptr_r;
    assign sram_webb = 1'b1;
    assign sram_oebb = oebb_r;
    assign sram_ib   = {DATA_W{1'b0}};

    assign st.s_ready = s_ready_r;
    assign st.m_valid = m_valid_r;
    assign st.m_data  = ob0_r;
    assign st.count   = count_r;

    // Pointers, occupancy counters and registered handshake outputs.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            wptr_r     <= {ADDR_W{1'b0}};
            rptr_r     <= {ADDR_W{1'b0}};
            mem_cnt_r  <= {(ADDR_W+1){1'b0}};
            count_r    <= {(ADDR_W+1){1'b0}};
            inflight_r <= 1'b0;
            ob_cnt_r   <= 2'd0;
            s_ready_r  <= 1'b0;
            m_valid_r  <= 1'b0;
            oebb_r     <= 1'b1;
        end else if (clr) begin
            wptr_r     <= {ADDR_W{1'b0}};
            rptr_r     <= {ADDR_W{1'b0}};
            mem_cnt_r  <= {(ADDR_W+1){1'b0}};
            count_r    <= {(ADDR_W+1){1'b0}};
            inflight_r <= 1'b0;
            ob_cnt_r   <= 2'd0;
            s_ready_r  <= 1'b1;
            m_valid_r  <= 1'b0;
            oebb_r     <= 1'b0;
        end else begin
            wptr_r     <= wptr_r + {{(ADDR_W-1){1'b0}}, push_s};
            rptr_r     <= rptr_r + {{(ADDR_W-1){1'b0}}, issue_s};
            mem_cnt_r  <= mem_cnt_next_s;
            count_r    <= mem_cnt_next_s + {{ADDR_W{1'b0}}, issue_s}
                          + {{(ADDR_W-1){1'b0}}, ob_cnt_next_s};
            inflight_r <= issue_s;
            ob_cnt_r   <= ob_cnt_next_s;
            s_ready_r  <= (mem_cnt_next_s < DEPTH_C);
            m_valid_r  <= (ob_cnt_next_s != 2'd0);
            oebb_r     <= 1'b0;
        end
    end

    // Output buffer data: ob0 is the head, ob1 the next word; captures land behind any held word.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            ob0_r <= {DATA_W{1'b0}};
            ob1_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            ob0_r <= ob0_r;
            ob1_r <= ob1_r;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (ob_cnt_r == 2'd0) begin
                        ob0_r <= sram_ob;
                    end else begin
                        ob1_r <= sram_ob;
                    end
                end
                2'b01: begin
                    ob0_r <= ob1_r;
                end
                2'b11: begin
                    if (ob_cnt_r == 2'd1) begin
                        ob0_r <= sram_ob;
                    end else begin
                        ob0_r <= ob1_r;
                        ob1_r <= sram_ob;
                    end
                end
                default: begin
                    ob0_r <= ob0_r;
                    ob1_r <= ob1_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomised bench for sram_fifo_ctrl against a queue-based FIFO reference and a behavioural SRAM.
module tb_sram_fifo_ctrl;
    logic        clk;
    logic        xrst;
    logic        clr;
    logic [6:0]  sram_aa;
    logic [15:0] sram_ia;
    logic        sram_csba, sram_weba, sram_reba, sram_oeba;
    logic [6:0]  sram_ab;
    logic        sram_csbb, sram_webb, sram_rebb, sram_oebb;
    logic [15:0] sram_ib;
    logic [15:0] sram_ob;
    logic [15:0] mem [0:127];

    logic [15:0] q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int pops_seen   = 0;
    int pushes_seen = 0;

    sram_fifo_ctrl_if #(.ADDR_W(7), .DATA_W(16)) bus ();

    sram_fifo_ctrl #(.ADDR_W(7), .DATA_W(16)) dut (
        .clk(clk), .xrst(xrst), .clr(clr), .st(bus),
        .sram_aa(sram_aa), .sram_ia(sram_ia), .sram_csba(sram_csba), .sram_weba(sram_weba),
        .sram_reba(sram_reba), .sram_oeba(sram_oeba),
        .sram_ab(sram_ab), .sram_csbb(sram_csbb), .sram_webb(sram_webb), .sram_rebb(sram_rebb),
        .sram_oebb(sram_oebb), .sram_ib(sram_ib), .sram_ob(sram_ob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port SRAM: synchronous write on A, registered read on B.
    always @(posedge clk) begin
        if (!sram_csba && !sram_weba) mem[sram_aa] <= sram_ia;
        if (!sram_csbb && !sram_rebb) sram_ob <= mem[sram_ab];
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock of stimulus; reference is a plain queue of held words.
    task automatic step(input logic sv, input logic [15:0] sd, input logic mr, input logic cl);
        logic do_push, do_pop;
        @(negedge clk);
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        clr         = cl;
        #1;
        do_push = sv & bus.s_ready & ~cl;
        do_pop  = bus.m_valid & mr;
        if (cl) begin
            check_eq("clr_csba", sram_csba, 1'b1);
            check_eq("clr_csbb", sram_csbb, 1'b1);
        end else begin
            check_eq("csba", sram_csba, !do_push);
        end
        if (!sram_csba && !sram_csbb) check_eq("addr_clash", (sram_aa == sram_ab), 1'b0);
        if (do_pop) begin
            if (q.size() == 0) check_eq("pop_empty", 1'b1, 1'b0);
            else begin
                check_eq("data", bus.m_data, q.pop_front());
                pops_seen++;
            end
        end
        if (cl) q.delete();
        else if (do_push) begin
            q.push_back(sd);
            pushes_seen++;
        end
        @(posedge clk);
        #1;
        check_eq("count", bus.count, q.size());
        if (q.size() < 128) check_eq("s_ready_room", bus.s_ready, 1'b1);
        if (q.size() == 130) check_eq("s_ready_full", bus.s_ready, 1'b0);
        if (q.size() == 0) check_eq("m_valid_empty", bus.m_valid, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            n++;
        end
        check_eq("drain_empty", q.size(), 0);
    endtask

    initial begin
        int base, p0, n;
        xrst = 1'b0; clr = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 16'hFFFF; bus.m_ready = 1'b0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_csba", sram_csba, 1'b1);
        check_eq("rst_weba", sram_weba, 1'b1);
        check_eq("rst_csbb", sram_csbb, 1'b1);
        check_eq("rst_rebb", sram_rebb, 1'b1);
        check_eq("rst_oebb", sram_oebb, 1'b1);
        check_eq("rst_s_ready", bus.s_ready, 1'b0);
        check_eq("rst_m_valid", bus.m_valid, 1'b0);
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_m_data", bus.m_data, 16'h0000);
        @(negedge clk);
        bus.s_valid = 1'b0;
        xrst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_s_ready", bus.s_ready, 1'b1);
        check_eq("rel_oebb", sram_oebb, 1'b0);
        check_eq("tie_oeba_reba_webb", {sram_oeba, sram_reba, sram_webb}, 3'b111);
        check_eq("tie_ib", sram_ib, 16'h0000);

        // latency of a single word
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_data = 16'hA5A5; bus.m_ready = 1'b0;
        #1;
        check_eq("lat_weba", {sram_csba, sram_weba}, 2'b00);
        check_eq("lat_aa", sram_aa, 7'd0);
        q.push_back(16'hA5A5);
        @(negedge clk);
        bus.s_valid = 1'b0;
        #1;
        check_eq("lat_rebb", {sram_csbb, sram_rebb}, 2'b00);
        check_eq("lat_ab", sram_ab, 7'd0);
        @(posedge clk);
        #1;
        check_eq("lat_m_valid_early", bus.m_valid, 1'b0);
        @(posedge clk);
        #1;
        check_eq("lat_m_valid", bus.m_valid, 1'b1);
        check_eq("lat_m_data", bus.m_data, 16'hA5A5);
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        // fill to 130 with consumer stalled, then drain in order
        base = pushes_seen; n = 0;
        while (pushes_seen - base < 130 && n < 400) begin
            step(1'b1, 16'(pushes_seen - base), 1'b0, 1'b0);
            n++;
        end
        check_eq("fill_pushed", pushes_seen - base, 130);
        check_eq("fill_ready", bus.s_ready, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        drain(400);

        // streaming: one word per cycle after the fill latency
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        base = pushes_seen; p0 = pops_seen;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 16'($urandom), 1'b1, 1'b0);
            if (i == 2) p0 = pops_seen;
        end
        check_eq("stream_pushes", pushes_seen - base, 1000);
        check_eq("stream_pops", pops_seen - p0, 997);
        drain(20);

        // random backpressure, 10k words
        base = pushes_seen; n = 0;
        while (pushes_seen - base < 10000 && n < 60000) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        check_eq("rand_pushes", pushes_seen - base, 10000);
        drain(400);

        // flush with a read in flight and a push pending
        base = pushes_seen; n = 0;
        while (pushes_seen - base < 20 && n < 100) begin
            step(1'b1, 16'(16'h0100 + 16'(pushes_seen - base)), 1'b0, 1'b0);
            n++;
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h5555, 1'b1, 1'b1);
        check_eq("flush_count", bus.count, 0);
        check_eq("flush_m_valid", bus.m_valid, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        p0 = pops_seen;
        drain(20);
        check_eq("flush_first_pop", pops_seen - p0, 1);

        // asynchronous reset mid-transfer
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b1;
        xrst = 1'b0;
        #1;
        check_eq("arst_csba", sram_csba, 1'b1);
        check_eq("arst_csbb", sram_csbb, 1'b1);
        check_eq("arst_count", bus.count, 0);
        check_eq("arst_m_valid", bus.m_valid, 1'b0);
        q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
